sar_search: RTL and testbench

- Successive-approximation search controller: the initiator side of the 16-bit magnitude comparator interface.
- Drives the comparator B operand (`trial`) and sign mode, and consumes its gt/eq/lt flags. The comparator's A operand is an externally held target.
- Recovers the target value in at most 16 probes, one per clock, in unsigned or two's-complement mode.
- Used by downstream datapath blocks to digitise or locate a value that is reachable only through a compare.

---
 rtl/sar_search.sv | 135 +++++++++++++
 tb/tb_sar_search.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search controller driving an external 16-bit magnitude comparator.
// Recovers a held target through at most WIDTH probes, in unsigned or two's-complement order.
module sar_search #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign_in,
  output logic [WIDTH-1:0] trial,
  output logic             cmp_sign,
  output logic             probe_valid,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic [4:0]       probes
);

  localparam int KW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [KW-1:0]    k_q, k_d;
  logic [4:0]       probes_q, probes_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cmp_sign_q, cmp_sign_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] probe_o;
  logic [WIDTH-1:0] o_upd;
  logic             flags_legal;
  logic             in_probe;

  // Flipping the MSB in signed mode maps two's-complement order onto unsigned order of o.
  assign mask        = {cmp_sign_q, {(WIDTH-1){1'b0}}};
  assign bit_k       = {{(WIDTH-1){1'b0}}, 1'b1} << k_q;
  assign probe_o     = o_q | bit_k;
  assign in_probe    = (state_q == PROBE);
  assign flags_legal = $onehot({gt, eq, lt});
  assign o_upd       = (gt || eq) ? (o_q | bit_k) : (o_q & ~bit_k);

  assign trial       = in_probe ? (probe_o ^ mask) : '0;
  assign probe_valid = in_probe;
  assign busy        = in_probe;
  assign cmp_sign    = cmp_sign_q;
  assign done        = done_q;
  assign error       = error_q;
  assign result      = result_q;
  assign probes      = probes_q;

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    o_d        = o_q;
    k_d        = k_q;
    probes_d   = probes_q;
    result_d   = result_q;
    cmp_sign_d = cmp_sign_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cmp_sign_d = sign_in;
          o_d        = '0;
          k_d        = KW'(WIDTH - 1);
          probes_d   = '0;
          state_d    = PROBE;
        end
      end

      PROBE: begin
        probes_d = probes_q + 5'd1;
        if (!flags_legal) begin
          // Comparator is misbehaving: abandon the run and keep the last good result.
          error_d = 1'b1;
          state_d = IDLE;
        end else if (eq && EARLY_EXIT) begin
          result_d = probe_o ^ mask;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          o_d = o_upd;
          if (k_q != '0) begin
            k_d = k_q - KW'(1);
          end else begin
            result_d = o_upd ^ mask;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      o_q        <= '0;
      k_q        <= '0;
      probes_q   <= '0;
      result_q   <= '0;
      cmp_sign_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      o_q        <= o_d;
      k_q        <= k_d;
      probes_q   <= probes_d;
      result_q   <= result_d;
      cmp_sign_q <= cmp_sign_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: one early-exit and one full-search instance, each driving
// a behavioural comparator that can be forced into an illegal flag pattern.
module tb_sar_search;

  logic        clk;
  logic        rst_n;
  logic [1:0]  start_v, sign_v, bad_v;
  logic [1:0]  gt_v, eq_v, lt_v;
  logic [1:0]  cs_v, pv_v, busy_v, done_v, err_v;
  logic [15:0] target_v [2];
  logic [15:0] trial_v  [2];
  logic [15:0] result_v [2];
  logic [4:0]  probes_v [2];

  int n_checks = 0;
  int n_errors = 0;

  sar_search #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sign_in(sign_v[0]),
    .trial(trial_v[0]), .cmp_sign(cs_v[0]), .probe_valid(pv_v[0]),
    .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .result(result_v[0]), .error(err_v[0]), .probes(probes_v[0])
  );

  sar_search #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sign_in(sign_v[1]),
    .trial(trial_v[1]), .cmp_sign(cs_v[1]), .probe_valid(pv_v[1]),
    .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .result(result_v[1]), .error(err_v[1]), .probes(probes_v[1])
  );

  // Behavioural comparator: {gt, eq, lt} of target against trial; bad forces gt and lt together.
  function automatic logic [2:0] cmp_model(input logic [15:0] a, input logic [15:0] b,
                                           input logic s, input logic bad);
    logic agt, alt;
    if (bad) return 3'b101;
    agt = s ? ($signed(a) > $signed(b)) : (a > b);
    alt = s ? ($signed(a) < $signed(b)) : (a < b);
    return {agt, a == b, alt};
  endfunction

  assign {gt_v[0], eq_v[0], lt_v[0]} = cmp_model(target_v[0], trial_v[0], cs_v[0], bad_v[0]);
  assign {gt_v[1], eq_v[1], lt_v[1]} = cmp_model(target_v[1], trial_v[1], cs_v[1], bad_v[1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after an edge with the instance idle (or showing done).
  task automatic do_start(input int u, input logic s, input logic [15:0] t);
    target_v[u] = t;
    sign_v[u]   = s;
    start_v[u]  = 1'b1;
    step();
    start_v[u]  = 1'b0;
  endtask

  // Starts in the first probe cycle; cyc counts cycles from there up to and including done.
  task automatic wait_done(input int u, output int cyc);
    cyc = 1;
    while (done_v[u] !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    check("done_seen", 32'(done_v[u]), 32'd1);
  endtask

  // Probe count for an early-exit search: eq lands when k reaches the lowest set offset bit.
  function automatic int ee_probes(input logic [15:0] t, input logic s);
    logic [15:0] v;
    v = t ^ {s, 15'h0};
    if (v == 16'h0) return 16;
    for (int i = 0; i < 16; i++) if (v[i]) return 16 - i;
    return 16;
  endfunction

  logic [15:0] a5c3_trials [16] = '{
    16'h8000, 16'hC000, 16'hA000, 16'hB000, 16'hA800, 16'hA400, 16'hA600, 16'hA500,
    16'hA580, 16'hA5C0, 16'hA5E0, 16'hA5D0, 16'hA5C8, 16'hA5C4, 16'hA5C2, 16'hA5C3
  };
  logic [15:0] bnd_targets [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

  initial begin
    int cyc;
    rst_n       = 1'b0;
    start_v     = '0;
    sign_v      = '0;
    bad_v       = '0;
    target_v[0] = 16'h0;
    target_v[1] = 16'h0;
    #12;
    check("rst_busy",   32'(busy_v[0]),   32'd0);
    check("rst_pv",     32'(pv_v[0]),     32'd0);
    check("rst_done",   32'(done_v[0]),   32'd0);
    check("rst_error",  32'(err_v[0]),    32'd0);
    check("rst_sign",   32'(cs_v[0]),     32'd0);
    check("rst_trial",  32'(trial_v[0]),  32'd0);
    check("rst_result", 32'(result_v[0]), 32'd0);
    check("rst_probes", 32'(probes_v[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Unsigned 0xA5C3: full SAR trial sequence, eq on the last probe.
    do_start(0, 1'b0, 16'hA5C3);
    check("a5c3_busy", 32'(busy_v[0]), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("a5c3_trial%0d", i), 32'(trial_v[0]), 32'(a5c3_trials[i]));
      step();
    end
    check("a5c3_done",   32'(done_v[0]),   32'd1);
    check("a5c3_busy0",  32'(busy_v[0]),   32'd0);
    check("a5c3_result", 32'(result_v[0]), 32'hA5C3);
    check("a5c3_probes", 32'(probes_v[0]), 32'd16);
    step();
    check("a5c3_done_pulse", 32'(done_v[0]), 32'd0);

    // Unsigned 0x8000: first probe hits eq; one busy cycle.
    do_start(0, 1'b0, 16'h8000);
    check("u8000_trial", 32'(trial_v[0]), 32'h8000);
    check("u8000_busy",  32'(busy_v[0]),  32'd1);
    step();
    check("u8000_done",   32'(done_v[0]),   32'd1);
    check("u8000_busy0",  32'(busy_v[0]),   32'd0);
    check("u8000_result", 32'(result_v[0]), 32'h8000);
    check("u8000_probes", 32'(probes_v[0]), 32'd1);

    // Start while done is high is accepted: signed -1, result held until its own done.
    do_start(0, 1'b1, 16'hFFFF);
    check("sffff_busy",   32'(busy_v[0]),   32'd1);
    check("sffff_trial0", 32'(trial_v[0]),  32'h0000);
    check("sffff_lt",     32'(lt_v[0]),     32'd1);
    check("sffff_held",   32'(result_v[0]), 32'h8000);
    sign_v[0] = 1'b0;
    step();
    check("sffff_trial1", 32'(trial_v[0]), 32'hC000);
    check("sffff_sign",   32'(cs_v[0]),    32'd1);
    wait_done(0, cyc);
    check("sffff_latency", 32'(cyc),         32'd16);
    check("sffff_result",  32'(result_v[0]), 32'hFFFF);
    check("sffff_probes",  32'(probes_v[0]), 32'd16);
    check("sffff_sign_end", 32'(cs_v[0]),    32'd1);

    // Signed 0x0000 resolves on the first probe.
    do_start(0, 1'b1, 16'h0000);
    wait_done(0, cyc);
    check("s0000_result", 32'(result_v[0]), 32'h0000);
    check("s0000_probes", 32'(probes_v[0]), 32'd1);

    // Boundary targets in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        do_start(0, m[0], bnd_targets[i]);
        wait_done(0, cyc);
        check($sformatf("bnd_res_%0d_%04h", m, bnd_targets[i]), 32'(result_v[0]), 32'(bnd_targets[i]));
        check($sformatf("bnd_prb_%0d_%04h", m, bnd_targets[i]), 32'(probes_v[0]),
              32'(ee_probes(bnd_targets[i], m[0])));
        check($sformatf("bnd_lat_%0d_%04h", m, bnd_targets[i]), 32'(cyc),
              32'(ee_probes(bnd_targets[i], m[0]) + 1));
      end
    end

    // Illegal flags on probe 3: error pulse, no done, result kept at 0x8000.
    do_start(0, 1'b0, 16'h1234);
    step();
    step();
    check("err_trial3", 32'(trial_v[0]), 32'h2000);
    bad_v[0] = 1'b1;
    step();
    bad_v[0] = 1'b0;
    check("err_pulse",  32'(err_v[0]),    32'd1);
    check("err_done",   32'(done_v[0]),   32'd0);
    check("err_busy",   32'(busy_v[0]),   32'd0);
    check("err_result", 32'(result_v[0]), 32'h8000);
    check("err_probes", 32'(probes_v[0]), 32'd3);
    step();
    check("err_pulse_end", 32'(err_v[0]), 32'd0);

    // Full-search instance: eq on probe 1 does not stop the run.
    do_start(1, 1'b0, 16'h8000);
    wait_done(1, cyc);
    check("full_latency", 32'(cyc),         32'd17);
    check("full_result",  32'(result_v[1]), 32'h8000);
    check("full_probes",  32'(probes_v[1]), 32'd16);

    // Reset during probe 7 aborts immediately.
    do_start(1, 1'b0, 16'h1234);
    for (int i = 0; i < 6; i++) step();
    check("rstmid_busy_before", 32'(busy_v[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_busy",   32'(busy_v[1]),   32'd0);
    check("rstmid_trial",  32'(trial_v[1]),  32'd0);
    check("rstmid_result", 32'(result_v[1]), 32'd0);
    check("rstmid_probes", 32'(probes_v[1]), 32'd0);
    check("rstmid_done",   32'(done_v[1]),   32'd0);
    check("rstmid_error",  32'(err_v[1]),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Restart after reset; a start pulse mid-search is ignored.
    do_start(1, 1'b0, 16'h1234);
    for (int i = 0; i < 4; i++) step();
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    wait_done(1, cyc);
    check("restart_latency", 32'(cyc),         32'd12);
    check("restart_result",  32'(result_v[1]), 32'h1234);
    check("restart_probes",  32'(probes_v[1]), 32'd16);
    step();
    check("restart_idle", 32'(busy_v[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
